// File: rtl/chunked_adder.sv
// Multi-cycle adder: sums a + b + cin CHUNK bits per clock, then holds the result
// behind a valid/ready handshake. Operands are captured on accept.
module chunked_adder #(
  parameter int WIDTH  = 8,
  parameter int CHUNK  = 2,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_adder: CHUNK must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, y_q, y_d;
  logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [CHUNK-1:0]   a_chunk, b_chunk;
  logic [CHUNK:0]     csum;
  logic               carry_into_msb;

  always_comb begin
    a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk = b_q[idx_q*CHUNK +: CHUNK];
    csum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Sum bit = a ^ b ^ carry-in, so the carry entering the top bit falls out for free.
    carry_into_msb = csum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    y_d       = y_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        y_d[idx_q*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        carry_d = csum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(N - 1)) begin
          cout_d  = csum[CHUNK];
          ovf_d   = (SIGNED != 0) ? (carry_into_msb ^ csum[CHUNK]) : csum[CHUNK];
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign y    = y_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder across three parameterisations:
// u8 (8/2/signed), u2 (2/1/unsigned), u88 (8/8/unsigned).
module tb_chunked_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       iv8 = 0, ir8, ov8, or8 = 1, cin8 = 0, co8, ovf8;
  logic [7:0] a8 = 0, b8 = 0, y8;
  logic       iv2 = 0, ir2, ov2, or2 = 1, cin2 = 0, co2, ovf2;
  logic [1:0] a2 = 0, b2 = 0, y2;
  logic       iv88 = 0, ir88, ov88, or88 = 1, cin88 = 0, co88, ovf88;
  logic [7:0] a88 = 0, b88 = 0, y88;

  chunked_adder #(.WIDTH(8), .CHUNK(2), .SIGNED(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .y(y8), .cout(co8), .ovf(ovf8));
  chunked_adder #(.WIDTH(2), .CHUNK(1), .SIGNED(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(cin2),
    .out_valid(ov2), .out_ready(or2), .y(y2), .cout(co2), .ovf(ovf2));
  chunked_adder #(.WIDTH(8), .CHUNK(8), .SIGNED(0)) u88 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv88), .in_ready(ir88), .a(a88), .b(b88), .cin(cin88),
    .out_valid(ov88), .out_ready(or88), .y(y88), .cout(co88), .ovf(ovf88));

  // Expected packing: {y[7:0], cout, ovf}
  logic [9:0] q8[$], q2[$], q88[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ov8 && or8) begin
      if (q8.size() == 0) chk("u8 unexpected result", 32'd1, 32'd0);
      else chk("u8 result", {22'd0, y8, co8, ovf8}, {22'd0, q8.pop_front()});
    end
    if (ov2 && or2) begin
      if (q2.size() == 0) chk("u2 unexpected result", 32'd1, 32'd0);
      else chk("u2 result", {22'd0, 6'd0, y2, co2, ovf2}, {22'd0, q2.pop_front()});
    end
    if (ov88 && or88) begin
      if (q88.size() == 0) chk("u88 unexpected result", 32'd1, 32'd0);
      else chk("u88 result", {22'd0, y88, co88, ovf88}, {22'd0, q88.pop_front()});
    end
  end

  function automatic logic get_ir(input int inst);
    case (inst)
      0: return ir8;
      1: return ir2;
      default: return ir88;
    endcase
  endfunction

  function automatic logic get_ov(input int inst);
    case (inst)
      0: return ov8;
      1: return ov2;
      default: return ov88;
    endcase
  endfunction

  task automatic set_in(input int inst, input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    case (inst)
      0: begin iv8 = v; a8 = a; b8 = b; cin8 = c; end
      1: begin iv2 = v; a2 = a[1:0]; b2 = b[1:0]; cin2 = c; end
      default: begin iv88 = v; a88 = a; b88 = b; cin88 = c; end
    endcase
  endtask

  // Issue one operation, check accept-to-valid latency; optionally wait for handoff.
  task automatic do_op(input int inst, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [9:0] exp, input int lat, input bit wait_done);
    int n;
    @(negedge clk);
    set_in(inst, 1'b1, a, b, c);
    n = 0;
    while (!get_ir(inst) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("accept timeout", 32'd1, 32'd0);
    case (inst)
      0: q8.push_back(exp);
      1: q2.push_back(exp);
      default: q88.push_back(exp);
    endcase
    @(posedge clk); #1;
    // Churn operands after accept; result must still reflect the captured values.
    set_in(inst, 1'b0, 8'hFF, 8'hFF, 1'b1);
    n = 0;
    while (!get_ov(inst) && n < 50) begin @(posedge clk); #1; n++; end
    chk("latency", n, lat);
    if (wait_done) begin
      n = 0;
      while (get_ov(inst) && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) chk("handoff timeout", 32'd1, 32'd0);
      chk("in_ready after handoff", {31'd0, get_ir(inst)}, 32'd1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset u8 out_valid", {31'd0, ov8}, 32'd0);
    chk("reset u8 in_ready", {31'd0, ir8}, 32'd1);
    chk("reset u8 y/cout/ovf", {22'd0, y8, co8, ovf8}, 32'd0);
    chk("reset u2 out_valid/in_ready", {30'd0, ov2, ir2}, 32'd1);
    chk("reset u88 out_valid/in_ready", {30'd0, ov88, ir88}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Width 2, chunk 1, unsigned: {y, cout, ovf}
    do_op(1, 8'd0, 8'd1, 1'b0, {8'd1, 1'b0, 1'b0}, 2, 1);
    do_op(1, 8'd1, 8'd1, 1'b0, {8'd2, 1'b0, 1'b0}, 2, 1);
    do_op(1, 8'd2, 8'd1, 1'b0, {8'd3, 1'b0, 1'b0}, 2, 1);
    do_op(1, 8'd3, 8'd1, 1'b0, {8'd0, 1'b1, 1'b1}, 2, 1);
    do_op(1, 8'd2, 8'd1, 1'b1, {8'd0, 1'b1, 1'b1}, 2, 1);

    // Width 8, chunk 2, signed
    do_op(0, 8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b1}, 4, 1);
    do_op(0, 8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b0}, 4, 1);
    do_op(0, 8'h80, 8'h80, 1'b0, {8'h00, 1'b1, 1'b1}, 4, 1);
    do_op(0, 8'h3C, 8'h41, 1'b0, {8'h7D, 1'b0, 1'b0}, 4, 1);
    do_op(0, 8'hFE, 8'hFF, 1'b1, {8'hFE, 1'b1, 1'b0}, 4, 1);

    // Width 8, chunk 8: single-cycle latency
    do_op(2, 8'h12, 8'h34, 1'b1, {8'h47, 1'b0, 1'b0}, 1, 1);
    do_op(2, 8'hF0, 8'h20, 1'b0, {8'h10, 1'b1, 1'b1}, 1, 1);

    // Backpressure: 0x55 + 0x2A + 1 = 0x80, signed overflow
    or8 = 1'b0;
    do_op(0, 8'h55, 8'h2A, 1'b1, {8'h80, 1'b0, 1'b1}, 4, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall out_valid", {31'd0, ov8}, 32'd1);
      chk("stall in_ready", {31'd0, ir8}, 32'd0);
      chk("stall y/cout/ovf", {22'd0, y8, co8, ovf8}, {22'd0, 8'h80, 1'b0, 1'b1});
    end
    @(negedge clk);
    or8 = 1'b1;
    @(posedge clk); #1;
    chk("after stall out_valid", {31'd0, ov8}, 32'd0);
    chk("after stall in_ready", {31'd0, ir8}, 32'd1);

    // Reset mid-BUSY abandons the operation
    @(negedge clk);
    set_in(0, 1'b1, 8'h11, 8'h22, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid-busy reset out_valid", {31'd0, ov8}, 32'd0);
    chk("mid-busy reset y", {24'd0, y8}, 32'd0);
    chk("mid-busy reset in_ready", {31'd0, ir8}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 8'd5, 8'd9, 1'b0, {8'd14, 1'b0, 1'b0}, 4, 1);

    repeat (3) @(posedge clk);
    chk("u8 queue drained", q8.size(), 32'd0);
    chk("u2 queue drained", q2.size(), 32'd0);
    chk("u88 queue drained", q88.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
